// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the memory port B arbiter and its
// round-robin picker.
package mem_arb_pkg;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Pointer width: clog2 of the requester count, at least one bit.
    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Lock counter width: wide enough to hold MAX_LOCK itself.
    function automatic int cnt_width(input int max_lock);
        return $clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester at
// or after the pointer, wrapping modulo N, plus the winner index.
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    int cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing memory port B among NUM_REQ masters, with a
// bounded lock for atomic read-modify-write and a 2-cycle read pipeline.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LOCK   = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [DATA_WIDTH-1:0]         mem_write_data,
    output logic                          mem_write_enable,
    input  logic [DATA_WIDTH-1:0]         mem_read_data
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int CNT_W = cnt_width(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LOCK);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    arb_state_e             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [DATA_WIDTH-1:0]  mem_wdata_q;
    logic                   mem_we_q;
    logic                   rd_pend_q;
    logic [PTR_W-1:0]       rd_owner_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [NUM_REQ-1:0]     rvalid_q;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign addr_arr[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // While locked, only the owner is visible to the picker.
    logic [NUM_REQ-1:0] req_eff;
    logic [PTR_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   win;
    logic               pick_valid;
    logic               xfer;

    assign req_eff  = (state_q == LOCKED) ? (req & (NUM_REQ'(1) << owner_q)) : req;
    assign pick_ptr = (state_q == LOCKED) ? owner_q : ptr_q;

    rr_priority_picker #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_picker (
        .req_i   (req_eff),
        .ptr_i   (pick_ptr),
        .gnt_o   (pick_gnt),
        .idx_o   (win),
        .valid_o (pick_valid)
    );

    assign gnt  = reset_n ? pick_gnt : '0;
    assign xfer = reset_n & pick_valid;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            OPEN: begin
                if (xfer) begin
                    ptr_d = (win == PTR_LAST) ? '0 : win + 1'b1;
                    if (lock[win]) begin
                        state_d = LOCKED;
                        owner_d = win;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                // Forced release still accepts an owner transfer this cycle.
                if ((xfer && !lock[owner_q]) || (cnt_q == CNT_MAX)) begin
                    state_d = OPEN;
                    ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = OPEN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= OPEN;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= '0;
            rdata_q     <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            mem_we_q  <= xfer & we[win];
            rd_pend_q <= xfer & ~we[win];
            if (xfer) begin
                mem_addr_q  <= addr_arr[win];
                mem_wdata_q <= wdata_arr[win];
                rd_owner_q  <= win;
            end
            // Memory read data settles at the falling edge of the issue cycle.
            if (rd_pend_q) begin
                rdata_q <= mem_read_data;
            end
            rvalid_q <= rd_pend_q ? (NUM_REQ'(1) << rd_owner_q) : '0;
        end
    end

    assign mem_address      = mem_addr_q;
    assign mem_write_data   = mem_wdata_q;
    assign mem_write_enable = mem_we_q;
    assign rdata            = rdata_q;
    assign rvalid           = rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a falling-edge port B memory model.
module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, mem_write_data, mem_read_data;
    logic [AW-1:0]   mem_address;
    logic            mem_write_enable;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:65535];

    mem_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(8)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req              (req),
        .lock             (lock),
        .we               (we),
        .addr             (addr),
        .wdata            (wdata),
        .gnt              (gnt),
        .rvalid           (rvalid),
        .rdata            (rdata),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    // Port B memory: acts on the falling edge, write-first on the read path.
    always @(negedge clock) begin
        if (mem_write_enable) begin
            mem[mem_address] <= mem_write_data;
        end
        mem_read_data <= mem_write_enable ? mem_write_data : mem[mem_address];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cmd(input int m, input logic r, input logic l, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[m]            = r;
        lock[m]           = l;
        we[m]             = w;
        addr[m*AW +: AW]  = a;
        wdata[m*DW +: DW] = d;
    endtask

    task automatic test_reset();
        req = '1; lock = '0; we = '0; addr = '0; wdata = '0;
        #2;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp %b", gnt, 3'b000); end
        checks++; if (mem_address !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp %h", mem_address, 16'h0000); end
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_write_enable); end
        checks++; if (rvalid !== 3'b000 || rdata !== 16'h0000) begin errors++; $display("FAIL reset_rd got rvalid %b rdata %h exp 000 0000", rvalid, rdata); end
        req = '0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic_read();
        set_cmd(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        set_cmd(2, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL t1_gnt_first got %b exp 001", gnt); end
        tick();
        req[0] = 1'b0;
        #1;
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL t1_gnt_second got %b exp 100", gnt); end
        checks++; if (mem_address !== 16'h0010 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL t1_issue0 got addr %h we %b exp 0010 0", mem_address, mem_write_enable); end
        tick();
        req = '0;
        #1;
        checks++; if (mem_address !== 16'h0020) begin errors++; $display("FAIL t1_issue2 got %h exp 0020", mem_address); end
        checks++; if (rvalid !== 3'b001 || rdata !== 16'h1111) begin errors++; $display("FAIL t1_rd0 got rvalid %b rdata %h exp 001 1111", rvalid, rdata); end
        tick();
        checks++; if (rvalid !== 3'b100 || rdata !== 16'h2222) begin errors++; $display("FAIL t1_rd2 got rvalid %b rdata %h exp 100 2222", rvalid, rdata); end
        tick();
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL t1_rv_clear got %b exp 000", rvalid); end
        $display("test_basic_read done");
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a_exp [N];
        logic [N-1:0]  g_exp;
        a_exp[0] = 16'h0100; a_exp[1] = 16'h0200; a_exp[2] = 16'h0300;
        set_cmd(0, 1'b1, 1'b0, 1'b0, a_exp[0], 16'h0);
        set_cmd(1, 1'b1, 1'b0, 1'b1, a_exp[1], 16'hAAAA);
        set_cmd(2, 1'b1, 1'b0, 1'b0, a_exp[2], 16'h0);
        for (int k = 0; k < 6; k++) begin
            g_exp = 3'b001 << (k % 3);
            #1;
            checks++; if (gnt !== g_exp) begin errors++; $display("FAIL t2_gnt%0d got %b exp %b", k, gnt, g_exp); end
            tick();
            checks++; if (mem_write_enable !== ((k % 3) == 1) || mem_address !== a_exp[k % 3]) begin
                errors++; $display("FAIL t2_issue%0d got we %b addr %h exp %b %h", k, mem_write_enable, mem_address, ((k % 3) == 1), a_exp[k % 3]);
            end
        end
        req = '0; we = '0;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL t2_idle_gnt got %b exp 000", gnt); end
        tick();
        checks++; if (mem_write_enable !== 1'b0 || mem_address !== 16'h0300) begin errors++; $display("FAIL t2_idle got we %b addr %h exp 0 0300", mem_write_enable, mem_address); end
        tick();
        tick();
        $display("test_round_robin done");
    endtask

    task automatic test_write_then_read();
        set_cmd(1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'hBEEF);
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL t3_gnt_wr got %b exp 010", gnt); end
        tick();
        we[1] = 1'b0;
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL t3_gnt_rd got %b exp 010", gnt); end
        checks++; if (mem_write_enable !== 1'b1 || mem_write_data !== 16'hBEEF) begin errors++; $display("FAIL t3_wr_issue got we %b data %h exp 1 beef", mem_write_enable, mem_write_data); end
        tick();
        req = '0;
        #1;
        checks++; if (mem_write_enable !== 1'b0 || mem_address !== 16'h1234) begin errors++; $display("FAIL t3_rd_issue got we %b addr %h exp 0 1234", mem_write_enable, mem_address); end
        tick();
        checks++; if (rvalid !== 3'b010 || rdata !== 16'hBEEF) begin errors++; $display("FAIL t3_rd got rvalid %b rdata %h exp 010 beef", rvalid, rdata); end
        tick();
        $display("test_write_then_read done");
    endtask

    task automatic test_lock_release();
        set_cmd(1, 1'b1, 1'b0, 1'b0, 16'h0400, 16'h0);
        for (int k = 0; k < 5; k++) begin
            set_cmd(0, 1'b1, (k < 4), 1'b1, 16'h0500 + 16'(k), 16'h0);
            #1;
            checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL t4_locked%0d got %b exp 001", k, gnt); end
            tick();
        end
        req[0] = 1'b0; lock = '0;
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL t4_after got %b exp 010", gnt); end
        tick();
        req = '0; we = '0;
        tick();
        $display("test_lock_release done");
    endtask

    task automatic test_lock_timeout();
        set_cmd(2, 1'b1, 1'b1, 1'b0, 16'h0600, 16'h0);
        set_cmd(0, 1'b1, 1'b0, 1'b0, 16'h0700, 16'h0);
        for (int k = 0; k < 9; k++) begin
            #1;
            checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL t5_owner%0d got %b exp 100", k, gnt); end
            tick();
        end
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL t5_forced got %b exp 001", gnt); end
        tick();
        req = '0; lock = '0;
        tick();
        tick();
        $display("test_lock_timeout done");
    endtask

    task automatic test_reset_midflight();
        set_cmd(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL t6_gnt got %b exp 001", gnt); end
        tick();
        req = '0;
        reset_n = 1'b0;
        #1;
        checks++; if (mem_address !== 16'h0 || rvalid !== 3'b000 || rdata !== 16'h0 || gnt !== 3'b000) begin
            errors++; $display("FAIL t6_async got addr %h rvalid %b rdata %h gnt %b exp all 0", mem_address, rvalid, rdata, gnt);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL t6_no_rv%0d got %b exp 000", k, rvalid); end
        end
        set_cmd(0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        set_cmd(2, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL t6_ptr0 got %b exp 001", gnt); end
        tick();
        req = '0;
        $display("test_reset_midflight done");
    endtask

    initial begin
        mem[16'h0010] <= 16'h1111;
        mem[16'h0020] <= 16'h2222;
        test_reset();
        test_basic_read();
        test_round_robin();
        test_write_then_read();
        test_lock_release();
        test_lock_timeout();
        test_reset_midflight();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single port B of the dual-port main memory among NUM_REQ masters: CPU data side, display fetch and I/O DMA. Port A stays owned by instruction fetch.
- Round-robin arbitration issues at most one access per cycle.
- Presents registered commands to the memory, which samples on the falling clock edge.
- Supports a bounded lock, so a master can perform an atomic read-modify-write sequence.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 16, memory word width
MAX_LOCK, 8, maximum cycles a lock may be held before forced release (>=2)

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-master access request (valid)
lock  in  NUM_REQ  per-master request to keep ownership after this access
we  in  NUM_REQ  per-master write (1) / read (0)
addr  in  NUM_REQ*ADDR_WIDTH  per-master address, master i in slice i
wdata  in  NUM_REQ*DATA_WIDTH  per-master write data
gnt  out  NUM_REQ  combinational accept; transfer occurs when req[i]&gnt[i]
rvalid  out  NUM_REQ  read data valid for master i
rdata  out  DATA_WIDTH  registered read data, shared bus
mem_address  out  ADDR_WIDTH  to memory port B address
mem_write_data  out  DATA_WIDTH  to memory port B write data
mem_write_enable  out  1  to memory port B write enable
mem_read_data  in  DATA_WIDTH  from memory port B read data

Behaviour:
- Reset (reset_n=0, asynchronous):
  - mem_address, mem_write_data, rdata = 0; mem_write_enable = 0; rvalid = 0.
  - Round-robin pointer = 0; state = OPEN; lock counter = 0.
  - gnt = 0 while reset_n is low.
  - Reset mid-operation drops in-flight reads; no rvalid follows release of reset.
- Handshake:
  - gnt is at most one-hot and depends only on req plus registered state, never on we/addr/wdata.
  - A master holds req and its command stable until it sees gnt. It may present a new command in the cycle after the transfer (back-to-back).
- Arbitration in OPEN:
  - The winner is the first requester at or after the pointer, modulo NUM_REQ.
  - After a transfer by master i, pointer = (i+1) mod NUM_REQ.
  - No request means gnt = 0 and the pointer is unchanged.
- Pipeline, transfer on rising edge ending cycle C:
  - Cycle C+1: mem_address, mem_write_data and mem_write_enable are driven from registers. mem_write_enable is 1 only for a write and for exactly one cycle. The memory acts at the falling edge inside C+1.
  - Cycle C+2 (reads only): rdata holds mem_read_data captured at the rising edge starting C+2, and rvalid[owner] = 1 for that one cycle.
  - Read latency is 2 cycles from transfer; throughput is 1 access per cycle.
- Idle cycles: mem_write_enable = 0; mem_address holds its last value.
- Write then read to the same address in consecutive transfers: the read returns the new data, because the write lands at the falling edge of the earlier cycle.
- Lock state machine (OPEN, LOCKED):
  - OPEN -> LOCKED on a transfer with lock[i]=1: owner = i, counter = 1.
  - In LOCKED only the owner can be granted; other requests wait and gnt to them is 0.
  - Counter increments every cycle in LOCKED, saturating at MAX_LOCK.
  - LOCKED -> OPEN on an owner transfer with lock=0; that access is the last one owned.
  - LOCKED -> OPEN when the counter reaches MAX_LOCK. Ownership ends at that edge, and an owner transfer in that same cycle is still accepted.
  - On either exit, pointer = (owner+1) mod NUM_REQ.
- Port A (instruction fetch) can write the same address at the same falling edge. That conflict is a software-level hazard and is not detected.
- Address and data widths pass straight through; no arithmetic beyond the pointer and counter wrap.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (OPEN, LOCKED);
  - the pointer width, clog2(NUM_REQ);
  - the counter width, clog2(MAX_LOCK+1).
- Sub-module rr_priority_picker: combinational. Takes a request vector and a pointer and returns a one-hot grant plus the winner index. It is reused by the display fetch path.

Test Plan:
1. Reset release, masters 0 and 2 assert a read of 0x0010 / 0x0020 in the same cycle -> gnt=001, then gnt=100. mem_address=0x0010 then 0x0020. rvalid[0] 2 cycles after the first transfer, rdata = mem[0x0010].
2. All 3 masters hold req for 6 cycles -> grant order 0,1,2,0,1,2; mem_write_enable pulses only on the writers' issue cycles.
3. Master 1 writes 0xBEEF to 0x1234, then immediately reads 0x1234 -> rvalid[1] with rdata=0xBEEF.
4. Master 0 transfers with lock=1, then 3 more accesses with lock=1, 1 with lock=0, while master 1 requests throughout -> master 1 gnt stays 0 for those 5 transfers and is granted on the next cycle.
5. Master 2 holds lock=1 with req continuously, MAX_LOCK=8 -> forced release after 8 LOCKED cycles; waiting master 0 is granted next; pointer = 0.
6. Assert reset_n=0 in the cycle after a read transfer -> rvalid never rises; all outputs 0 immediately. After release, the first request is granted with pointer 0.
